// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic        err;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// Synchronous FIFO holding fetched {err, pc, instr} entries; flush empties it in one edge.
module fetch_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: PC and imem request credit, outstanding/discard tracking, and the decode-facing buffer.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MAX_OUTST  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_err_o
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          r_req;
    logic [31:0]   r_addr;
    logic          r_stale;
    logic [31:0]   r_redir_pc;
    logic [31:0]   r_resp_pc;
    logic [OW-1:0] r_outst;
    logic [OW-1:0] r_discard;

    logic          w_gnt;
    logic          w_keep;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic [CW-1:0] w_fifo_cnt;
    logic [31:0]   w_redir_pc;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;
    logic          w_req_n;
    int            w_outst_n;
    int            w_fifo_n;
    int            w_disc_n;

    assign w_gnt        = r_req && imem_gnt_i;
    assign w_redir_pc   = word_align(redirect_pc_i);
    assign w_keep       = imem_rvalid_i && (r_discard == '0) && !redirect_i;
    assign w_pop        = !w_empty && instr_ready_i;
    assign w_push_entry = {imem_err_i, r_resp_pc, imem_rdata_i};

    fetch_fifo #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_flush (redirect_i),
        .i_push  (w_keep),
        .i_pop   (w_pop),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_cnt)
    );

    // Credit is evaluated on next-cycle counts so a new request can follow a grant back to back.
    always_comb begin
        w_outst_n = int'(r_outst) + (w_gnt ? 1 : 0) - (imem_rvalid_i ? 1 : 0);
        w_fifo_n  = 0;
        w_disc_n  = w_outst_n;
        if (!redirect_i) begin
            w_fifo_n = int'(w_fifo_cnt) + (w_keep ? 1 : 0) - (w_pop ? 1 : 0);
            w_disc_n = int'(r_discard) - ((imem_rvalid_i && r_discard != '0) ? 1 : 0)
                       + ((w_gnt && r_stale) ? 1 : 0);
        end
        if (r_req && !imem_gnt_i) begin
            w_req_n = 1'b1;
        end else begin
            w_req_n = (w_outst_n + w_fifo_n < FIFO_DEPTH) && (w_outst_n < MAX_OUTST)
                      && (w_disc_n != MAX_OUTST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_stale    <= 1'b0;
            r_redir_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_outst    <= '0;
            r_discard  <= '0;
        end else begin
            r_req     <= w_req_n;
            r_outst   <= OW'(w_outst_n);
            r_discard <= OW'(w_disc_n);
            if (redirect_i) begin
                r_resp_pc <= w_redir_pc;
                // An ungranted request must keep its address; the new target waits behind it.
                if (r_req && !imem_gnt_i) begin
                    r_stale    <= 1'b1;
                    r_redir_pc <= w_redir_pc;
                end else begin
                    r_stale <= 1'b0;
                    r_addr  <= w_redir_pc;
                end
            end else begin
                if (w_keep) r_resp_pc <= r_resp_pc + 32'd4;
                if (w_gnt) begin
                    r_stale <= 1'b0;
                    r_addr  <= r_stale ? r_redir_pc : r_addr + 32'd4;
                end
            end
        end
    end

    assign imem_req_o    = r_req;
    assign imem_addr_o   = r_addr;
    assign instr_valid_o = !w_empty;
    assign instr_o       = w_empty ? NOP_INSTR : w_head.instr;
    assign pc_o          = w_empty ? 32'h0 : w_head.pc;
    assign instr_err_o   = !w_empty && w_head.err;

    a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        w_keep |-> (!w_full || w_pop));
    a_outst_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        int'(r_outst) <= MAX_OUTST);
    a_rvalid_has_outst: assert property (@(posedge clk_i) disable iff (rst_i)
        imem_rvalid_i |-> (r_outst != '0));

endmodule
